one_sweep_ctrl: RTL and testbench

- Sequencer that exercises the 4-input enabled single-output function unit (inputs En, W[3:0]; output f) exhaustively in hardware.
- On a start pulse it drives En=1 and steps W through 0..2^N-1, holds each code for a settle window, then samples f into a truth-table register.
- Sits between a host/test controller (start/abort/done handshake) and the function unit; it is the block that owns the unit's En and W inputs.

---
 rtl/one_sweep_ctrl_pkg.sv | 15 +
 rtl/one_sweep_ctrl_if.sv | 27 ++
 rtl/one_sweep_ctrl_settle_timer.sv | 29 ++
 rtl/one_sweep_ctrl.sv | 140 ++++++++++++++
 tb/tb_one_sweep_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/one_sweep_ctrl_pkg.sv
// Shared definitions for the exhaustive sweep sequencer: state encoding and
// default geometry of the function unit under test.
package one_pkg;

  localparam int N_DEF      = 4;
  localparam int SETTLE_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/one_sweep_ctrl_if.sv
// Bundle of the host handshake and the function-unit drive/sense signals.
// The master side is the host plus function unit; the slave side is the sequencer.
interface one_sweep_if #(
  parameter int N = one_pkg::N_DEF
);

  logic                start;
  logic                abort;
  logic                f_in;
  logic                en_out;
  logic [N-1:0]        w_out;
  logic                busy;
  logic                done;
  logic [(1<<N)-1:0]   table_out;
  logic [N:0]          ones_cnt;

  modport master (
    output start, abort, f_in,
    input  en_out, w_out, busy, done, table_out, ones_cnt
  );

  modport slave (
    input  start, abort, f_in,
    output en_out, w_out, busy, done, table_out, ones_cnt
  );

endinterface

// File: rtl/one_sweep_ctrl_settle_timer.sv
// Settle-window counter: counts while enabled, wraps to zero on expire, and
// expire flags the last cycle of the window (count == SETTLE-1).
module one_settle_timer #(
  parameter int SETTLE = one_pkg::SETTLE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  logic [3:0] count_reg;

  assign expire = enable && (count_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 4'd0;
    end else if (clear) begin
      count_reg <= 4'd0;
    end else if (enable) begin
      count_reg <= expire ? 4'd0 : count_reg + 4'd1;
    end
  end

endmodule

// File: rtl/one_sweep_ctrl.sv
// Exhaustive sweep sequencer: drives En/W of a 4-input function unit through
// every code, samples f after a settle window and accumulates a truth table.
module one_sweep_ctrl
  import one_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  one_sweep_if.slave bus
);

  localparam int           T      = 1 << N;
  localparam logic [N-1:0] W_LAST = {N{1'b1}};
  localparam logic [N-1:0] W_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [T-1:0] HOT0   = {{(T-1){1'b0}}, 1'b1};

  state_t       state_reg;
  state_t       state_next;
  logic [N-1:0] w_reg;
  logic [N:0]   ones_reg;
  logic [T-1:0] table_reg;
  logic [T-1:0] code_hot;

  logic accept;
  logic active;
  logic last_code;
  logic sample_wr;
  logic settle_expire;
  logic en_comb;
  logic busy_comb;
  logic done_comb;

  assign active    = (state_reg == ST_DRIVE) || (state_reg == ST_SAMPLE);
  // abort outranks start so a simultaneous pair leaves the block idle
  assign accept    = (state_reg == ST_IDLE) && bus.start && !bus.abort;
  assign last_code = (w_reg == W_LAST);
  assign sample_wr = (state_reg == ST_SAMPLE) && !bus.abort;
  assign code_hot  = HOT0 << w_reg;

  one_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state_reg != ST_DRIVE) || bus.abort),
    .enable (state_reg == ST_DRIVE),
    .expire (settle_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (bus.abort)          state_next = ST_IDLE;
        else if (settle_expire) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (bus.abort)      state_next = ST_IDLE;
        else if (last_code) state_next = ST_DONE;
        else                state_next = ST_DRIVE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decode straight from the state so a reset drops En without a clock
  always_comb begin
    en_comb   = 1'b0;
    busy_comb = 1'b0;
    done_comb = 1'b0;
    case (state_reg)
      ST_DRIVE, ST_SAMPLE: begin
        en_comb   = 1'b1;
        busy_comb = 1'b1;
      end
      ST_DONE: begin
        done_comb = 1'b1;
      end
      default: begin
        en_comb   = 1'b0;
      end
    endcase
  end

  // The terminal code returns W to 0 for DONE instead of wrapping into DRIVE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_reg    <= '0;
      ones_reg <= '0;
    end else if (accept) begin
      w_reg    <= '0;
      ones_reg <= '0;
    end else if (sample_wr) begin
      ones_reg <= ones_reg + {{N{1'b0}}, bus.f_in};
      w_reg    <= last_code ? '0 : w_reg + W_ONE;
    end else if (active && bus.abort) begin
      w_reg    <= '0;
    end
  end

  for (genvar gi = 0; gi < T; gi++) begin : g_table
    logic bit_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bit_reg <= 1'b0;
      end else if (accept) begin
        bit_reg <= 1'b0;
      end else if (sample_wr && code_hot[gi]) begin
        bit_reg <= bus.f_in;
      end
    end

    assign table_reg[gi] = bit_reg;
  end

  assign bus.en_out    = en_comb;
  assign bus.busy      = busy_comb;
  assign bus.done      = done_comb;
  assign bus.w_out     = w_reg;
  assign bus.table_out = table_reg;
  assign bus.ones_cnt  = ones_reg;

endmodule

// File: tb/tb_one_sweep_ctrl.sv
// Directed and randomized sweeps of one_sweep_ctrl against a cycle-count model
// of which codes get sampled before an abort and when done fires.
module tb_one_sweep_ctrl;
  import one_pkg::*;

  localparam int N      = 4;
  localparam int SETTLE = 2;
  localparam int T      = 1 << N;
  localparam int PER    = SETTLE + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [T-1:0] fu_lut = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  one_sweep_if #(.N(N)) bus ();

  // function unit model: f = En & LUT[W]
  assign bus.f_in = bus.en_out & fu_lut[bus.w_out];

  one_sweep_ctrl #(
    .N      (N),
    .SETTLE (SETTLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Code k is sampled in cycle PER*(k+1); an abort in cycle c suppresses that
  // cycle's sample and everything after it.
  task automatic model(input logic [T-1:0] lut, input int abort_cyc,
                       output logic [T-1:0] tbl, output int ones, output int done_cyc);
    tbl  = '0;
    ones = 0;
    for (int k = 0; k < T; k++) begin
      if (abort_cyc == 0 || PER * (k + 1) < abort_cyc) begin
        tbl[k] = lut[k];
        ones  += int'(lut[k]);
      end
    end
    done_cyc = (abort_cyc == 0 || abort_cyc > T * PER) ? T * PER + 1 : 0;
  endtask

  task automatic run_sweep(input string name, input logic [T-1:0] lut,
                           input int abort_cyc, input int restart_cyc,
                           output logic [T-1:0] tbl_exp);
    int ones_exp, done_exp, done_seen, done_pulses, w_exp;
    logic busy_exp;
    model(lut, abort_cyc, tbl_exp, ones_exp, done_exp);
    fu_lut    = lut;
    bus.start = 1'b1;
    step();
    bus.start   = 1'b0;
    done_seen   = 0;
    done_pulses = 0;
    for (int c = 1; c <= T * PER + 4; c++) begin
      bus.abort = (c == abort_cyc);
      bus.start = (c == restart_cyc);
      busy_exp  = (c <= T * PER) && (abort_cyc == 0 || c <= abort_cyc);
      w_exp     = busy_exp ? (c - 1) / PER : 0;
      check($sformatf("%s busy c%0d", name, c), 32'(bus.busy), 32'(busy_exp));
      check($sformatf("%s en c%0d", name, c), 32'(bus.en_out), 32'(busy_exp));
      check($sformatf("%s w c%0d", name, c), 32'(bus.w_out), 32'(w_exp));
      if (bus.done === 1'b1) begin
        done_pulses++;
        if (done_seen == 0) done_seen = c;
      end
      step();
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check({name, " done_cycle"}, 32'(done_seen), 32'(done_exp));
    check({name, " done_pulses"}, 32'(done_pulses), (done_exp != 0) ? 32'd1 : 32'd0);
    check({name, " table"}, 32'(bus.table_out), 32'(tbl_exp));
    check({name, " ones"}, 32'(bus.ones_cnt), 32'(ones_exp));
    $display("sweep %s lut=%04h abort=%0d restart=%0d table=%04h ones=%0d done_cyc=%0d",
             name, lut, abort_cyc, restart_cyc, bus.table_out, bus.ones_cnt, done_seen);
  endtask

  initial begin
    logic [T-1:0] tbl;
    logic [T-1:0] lut;
    int ab, rs;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset en", 32'(bus.en_out), 32'd0);
    check("reset w", 32'(bus.w_out), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset table", 32'(bus.table_out), 32'd0);
    check("reset ones", 32'(bus.ones_cnt), 32'd0);
    $display("reset checked");
    rst_n = 1'b1;
    step();

    run_sweep("onehot", 16'h0116, 0, 0, tbl);
    check("onehot table const", 32'(bus.table_out), 32'h0116);
    check("onehot ones const", 32'(bus.ones_cnt), 32'd4);

    run_sweep("allones", 16'hFFFF, 0, 0, tbl);
    check("allones ones const", 32'(bus.ones_cnt), 32'h10);

    run_sweep("abort20", 16'h0116, 20, 0, tbl);
    check("abort20 table const", 32'(bus.table_out), 32'h0016);
    check("abort20 ones const", 32'(bus.ones_cnt), 32'd3);

    run_sweep("restart10", 16'h0116, 0, 10, tbl);
    run_sweep("start_in_done", 16'hA5C3, 0, T * PER + 1, tbl);
    run_sweep("abort_in_done", 16'h3C0F, T * PER + 1, 0, tbl);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start+abort busy", 32'(bus.busy), 32'd0);
    check("start+abort en", 32'(bus.en_out), 32'd0);
    check("start+abort table", 32'(bus.table_out), 32'(tbl));
    step();
    check("start+abort busy later", 32'(bus.busy), 32'd0);
    $display("start+abort in idle table=%04h", bus.table_out);

    fu_lut    = 16'h0116;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (21) step();
    check("midreset w before", 32'(bus.w_out), 32'd7);
    check("midreset busy before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset en", 32'(bus.en_out), 32'd0);
    check("midreset w", 32'(bus.w_out), 32'd0);
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    check("midreset table", 32'(bus.table_out), 32'd0);
    check("midreset ones", 32'(bus.ones_cnt), 32'd0);
    $display("async reset at w=7 checked");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    run_sweep("after_reset", 16'h0116, 0, 0, tbl);

    for (int i = 0; i < 8; i++) begin
      lut = 16'($urandom);
      ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, T * PER)) : 0;
      rs  = (ab == 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, T * PER + 1)) : 0;
      run_sweep($sformatf("rand%0d", i), lut, ab, rs, tbl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
